// File: rtl/res_stream_buf.sv
// res_stream_buf: word-addressed result RAM streamed out in address order over valid/ready after commit.
// Define RES_BUF_WIPE_EN to zero the stored result after readout.
module res_stream_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WORDS  = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done
);
`ifdef RES_BUF_WIPE_EN
  typedef enum logic [1:0] {LOAD, DRAIN, WIPE} state_t;
`else
  typedef enum logic [0:0] {LOAD, DRAIN} state_t;
`endif
  // One extra pointer bit keeps the terminal compare exact when NUM_WORDS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NW   = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_WORDS - 1);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  rd_en, we, accept;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  assign accept    = out_valid_q && out_ready;
  assign busy      = state_q != LOAD;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    we          = 1'b0;
    waddr       = wr_addr;
    wdata       = wr_data;
    case (state_q)
      LOAD: begin
        we = wr_en;
        if (commit) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        rd_en = rd_ptr_q < NW && (!out_valid_q || out_ready);
        if (rd_en) begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = rd_ptr_q == LAST;
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (accept && out_last_q) begin
`ifdef RES_BUF_WIPE_EN
          state_d  = WIPE;
          rd_ptr_d = '0;
`else
          state_d = LOAD;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef RES_BUF_WIPE_EN
      WIPE: begin
        we       = 1'b1;
        waddr    = rd_ptr_q[ADDR_WIDTH-1:0];
        wdata    = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_q == LAST) begin
          state_d = LOAD;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      if (rd_en) out_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end
endmodule

// File: tb/tb_res_stream_buf.sv
// tb_res_stream_buf: randomized fill/stream scenarios checked against an array model of the stored result.
module tb_res_stream_buf;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NA = 4;
  localparam int NB = 8;
`ifdef RES_BUF_WIPE_EN
  localparam int GAP = NA + 1;
`else
  localparam int GAP = 1;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, wr_en, commit, out_ready, busy, out_valid, out_last, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, out_data;
  logic wr_en_b, commit_b, out_ready_b, busy_b, out_valid_b, out_last_b, done_b;
  logic [AW-1:0] wr_addr_b;
  logic [DW-1:0] wr_data_b, out_data_b;
  logic [DW-1:0] mem_a [NA];
  logic [DW-1:0] mem_b [NB];
  int vectors = 0, errors = 0;

  res_stream_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NA)) dut_a (
    .clock(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done));

  res_stream_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NB)) dut_b (
    .clock(clk), .reset(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .commit(commit_b), .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .done(done_b));

  task automatic write_a(input int addr, input logic [DW-1:0] data, input bit com);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data; commit = com;
    mem_a[addr] = data;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic fill_a(input bit fixed);
    for (int i = 0; i < NA; i++) write_a(i, fixed ? DW'(32'hA0 + i) : DW'($urandom), 1'b0);
  endtask

  task automatic commit_a;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // mode 0: ready held high, 1: fixed 1,0,0,1,0,1,1 pattern, 2: random ready
  task automatic stream_a(input int mode, input bit poke);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int idx = 0, last_acc = -100;
    bit stalled = 1'b0, fin = 1'b0, rdy;
    logic [DW-1:0] prev = '0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (done) begin
        vectors++;
        if (idx != NA || cyc - last_acc != GAP || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_timing: words %0d gap %0d busy %b, want %0d gap %0d busy 0", idx, cyc - last_acc, busy, NA, GAP);
        end
        fin = 1'b1;
      end else if (idx == NA) begin
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL tail_busy: busy %b valid %b, want busy 1 valid 0", busy, out_valid);
        end
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 7] : 1'($urandom_range(0, 1));
      if (stalled) begin
        vectors++;
        if (out_data !== prev || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: data %h valid %b, want %h valid 1", out_data, out_valid, prev);
        end
      end
      if (out_valid && rdy) begin
        vectors++;
        if (idx >= NA) begin
          errors++;
          $display("FAIL extra_word: got %h after %0d words, want none", out_data, NA);
        end else if (out_data !== mem_a[idx] || out_last !== (idx == NA - 1) || (mode == 0 && cyc != idx + 1)) begin
          errors++;
          $display("FAIL word%0d: data %h last %b cyc %0d, want %h last %b", idx, out_data, out_last, cyc, mem_a[idx], idx == NA - 1);
        end
        last_acc = cyc;
        idx++;
      end
      stalled = out_valid && !rdy;
      prev = out_data;
      out_ready = rdy;
      wr_en = poke && cyc == 2; commit = poke && cyc == 2; wr_addr = '0; wr_data = 32'h77;
      @(negedge clk);
    end
    out_ready = 1'b0; wr_en = 1'b0; commit = 1'b0;
    if (!fin) begin
      vectors++; errors++;
      $display("FAIL stream_timeout: no done after %0d words, want done after %0d", idx, NA);
    end
`ifdef RES_BUF_WIPE_EN
    for (int i = 0; i < NA; i++) mem_a[i] = '0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 2;
    if ({busy, out_valid, out_last, done, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_a: busy %b valid %b last %b done %b data %h, want all 0", busy, out_valid, out_last, done, out_data);
    end
    if ({busy_b, out_valid_b, out_last_b, done_b, out_data_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: busy %b valid %b last %b done %b data %h, want all 0", busy_b, out_valid_b, out_last_b, done_b, out_data_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_stream;
    fill_a(1'b1); commit_a(); stream_a(0, 1'b0);
  endtask

  task automatic test_backpressure;
    fill_a(1'b1); commit_a(); stream_a(1, 1'b0);
  endtask

  task automatic test_write_commit;
    for (int i = 0; i < NA - 1; i++) write_a(i, DW'(32'hA0 + i), 1'b0);
    write_a(NA - 1, 32'h55, 1'b1);
    stream_a(0, 1'b1);
    commit_a();
    stream_a(0, 1'b0);
  endtask

  task automatic test_reset_mid_drain;
    int n = 0;
    fill_a(1'b0); commit_a();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
      if (out_valid) n++;
      if (n < 2) @(negedge clk);
    end
    vectors++;
    if (n != 2 || out_data !== mem_a[1]) begin
      errors++;
      $display("FAIL pre_reset_word: count %0d data %h, want 2 and %h", n, out_data, mem_a[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid %b busy %b done %b, want 0 0 0", out_valid, busy, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: done %b busy %b, want 0 0", done, busy);
    end
    commit_a(); stream_a(0, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      fill_a(1'b0); commit_a(); stream_a(2, 1'b0);
    end
  endtask

  task automatic test_boundary;
    int n = 0, dn = 0;
    for (int i = 0; i < NB; i++) begin
      mem_b[i] = $urandom; wr_en_b = 1'b1; wr_addr_b = AW'(i); wr_data_b = mem_b[i];
      @(negedge clk);
    end
    wr_en_b = 1'b0; commit_b = 1'b1;
    @(negedge clk);
    commit_b = 1'b0; out_ready_b = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid_b) begin
        vectors++;
        if (n >= NB) begin
          errors++;
          $display("FAIL boundary_extra: word %0d data %h, want no more than %0d", n, out_data_b, NB);
        end else if (out_data_b !== mem_b[n] || out_last_b !== (n == NB - 1)) begin
          errors++;
          $display("FAIL boundary_word%0d: data %h last %b, want %h last %b", n, out_data_b, out_last_b, mem_b[n], n == NB - 1);
        end
        n++;
      end
      if (done_b) dn++;
      @(negedge clk);
    end
    out_ready_b = 1'b0;
    vectors++;
    if (n != NB || dn != 1) begin
      errors++;
      $display("FAIL boundary_count: words %0d dones %0d, want %0d and 1", n, dn, NB);
    end
  endtask

`ifdef RES_BUF_WIPE_EN
  task automatic test_wipe;
    fill_a(1'b1); commit_a(); stream_a(0, 1'b0);
    commit_a(); stream_a(0, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; commit = 1'b0; out_ready = 1'b0; wr_addr = '0; wr_data = '0;
    wr_en_b = 1'b0; commit_b = 1'b0; out_ready_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_write_commit();
    test_reset_mid_drain();
    test_random();
    test_boundary();
`ifdef RES_BUF_WIPE_EN
    test_wipe();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/res_stream_buf.md
Name: res_stream_buf

Overview:
Parametrised successor to the always-write single-port result RAM. Holds one multi-word ModExp result, written word-addressed by the exponentiation datapath. On a commit pulse, it streams the result out in address order over a valid/ready interface. Sits between the ModExp core's result writeback and the host/UART readout logic, and replaces the fixed-width M4K result wrapper.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 7, address width; RAM depth is 2**ADDR_WIDTH
NUM_WORDS, 128, words per result (4096/32); legal range 1..2**ADDR_WIDTH

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  write strobe from ModExp core
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  DATA_WIDTH  write data
commit  in  1  one-cycle pulse: result complete, start readout
busy  out  1  high when not in LOAD
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer accepts the word when out_valid && out_ready
out_data  out  DATA_WIDTH  streamed result word
out_last  out  1  high with the word at address NUM_WORDS-1
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: busy=0, out_valid=0, out_last=0, done=0, out_data=0, state=LOAD, rd_ptr=0. RAM contents are not cleared by reset.
- Storage: inferred or altsyncram single-clock RAM with synchronous read and 1-cycle read latency. A read enable is required; q holds its value when no read is issued.
- FSM states: LOAD, DRAIN, plus WIPE when the optional feature is compiled in.
- LOAD:
  - wr_en writes wr_data to wr_addr on the clock edge.
  - commit moves the FSM to DRAIN next cycle and clears rd_ptr to 0.
  - wr_en and commit in the same cycle: the write is performed and the commit is taken.
- DRAIN:
  - wr_en is ignored (no write). commit is ignored.
  - A read is issued at rd_ptr when rd_ptr < NUM_WORDS and (!out_valid || out_ready). rd_ptr increments on each issued read.
  - out_valid is set the cycle after an issued read. It clears when the word is accepted and no new read was issued in the same cycle.
  - Full throughput: with out_ready held high, one word per cycle.
  - Latency: commit at cycle t gives DRAIN at t+1, first read at t+1, and out_valid=1 with word 0 at t+2.
  - out_data must stay stable while out_valid && !out_ready.
  - out_last is registered alongside out_data and is high only for address NUM_WORDS-1.
  - When the out_last word is accepted: done pulses the next cycle, out_valid drops, and the FSM returns to LOAD (or enters WIPE).
- busy is 1 in DRAIN and WIPE.
- Reset mid-DRAIN:
  - Next cycle: LOAD, out_valid=0, rd_ptr=0, no done pulse.
  - Stored data is retained, except as described under the optional feature.
- NUM_WORDS=1: a single word carrying out_last=1.
- Width rule: rd_ptr is ADDR_WIDTH+1 bits so that the terminal compare with NUM_WORDS=2**ADDR_WIDTH does not wrap.

Optional Feature:
Macro RES_BUF_WIPE_EN (key-material hygiene).
- Defined:
  - After the last word is accepted, the FSM enters WIPE and writes zero to addresses 0..NUM_WORDS-1, one per cycle (NUM_WORDS cycles) using rd_ptr as the wipe address. It then returns to LOAD.
  - done pulses in the cycle WIPE completes, not after the last accept.
  - busy=1 throughout WIPE. wr_en and commit are ignored during WIPE.
  - Reset mid-WIPE aborts to LOAD; the partially wiped contents remain.
- Undefined: no WIPE state. done pulses the cycle after the last accept, and contents persist until overwritten.

Test Plan:
- Fill and stream (NUM_WORDS=4, DATA_WIDTH=32): write 0xA0..0xA3 to addresses 0..3, commit, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles starting 2 cycles after commit. out_last only with 0xA3, done 1 cycle after, busy back to 0.
- Backpressure: same fill, out_ready toggled 1,0,0,1,0,1,1 -> each word presented exactly once, out_data stable while stalled, order preserved, no duplicates or drops.
- Write+commit same cycle: write 0x55 to address 3 with commit -> stream ends with 0x55 at out_last. A write of 0x77 to address 0 during DRAIN has no effect; a second stream shows the original word 0.
- Reset mid-drain: reset after word 1 is accepted -> out_valid=0 and busy=0 next cycle, no done. A new commit re-streams all 4 words from address 0.
- Boundary: NUM_WORDS=2**ADDR_WIDTH=8, out_ready=1 -> exactly 8 words, out_last on the 8th, no 9th valid.
- RES_BUF_WIPE_EN: after the stream, busy stays 1 for 4 cycles and done pulses at WIPE end. Commit without rewriting -> 4 words of 0x00000000.
